// File: rtl/host_axil_pkg.sv
// Shared types and constants for the host-to-AXI4-Lite control bridge.
// Optional response watchdog is enabled by defining HOST_AXIL_TIMEOUT_EN.
package host_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP,
        DRAIN
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Anything but OKAY is reported to the host; EXOKAY has no meaning on AXI4-Lite.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_EXOKAY) || (resp == AXI_RESP_SLVERR) ||
               (resp == AXI_RESP_DECERR) || (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/host_axil_bridge_if.sv
// AXI4-Lite control channel bundle with manager (master) and subordinate (slave) views.
// Optional response watchdog of the bridge is enabled by defining HOST_AXIL_TIMEOUT_EN.
interface host_axil_bridge_if #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 32,
    parameter int STRB_BITS = DATA_BITS / 8
);
    logic                 awvalid;
    logic                 awready;
    logic [ADDR_BITS-1:0] awaddr;
    logic                 wvalid;
    logic                 wready;
    logic [DATA_BITS-1:0] wdata;
    logic [STRB_BITS-1:0] wstrb;
    logic                 arvalid;
    logic                 arready;
    logic [ADDR_BITS-1:0] araddr;
    logic                 rvalid;
    logic                 rready;
    logic [DATA_BITS-1:0] rdata;
    logic [1:0]           rresp;
    logic                 bvalid;
    logic                 bready;
    logic [1:0]           bresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready, bready,
        input  awready, wready, arready, rvalid, rdata, rresp, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready, bready,
        output awready, wready, arready, rvalid, rdata, rresp, bvalid, bresp
    );

endinterface

// File: rtl/host_axil_watchdog.sv
// Cycle counter that flags when a response wait has lasted TIMEOUT_CYCLES cycles.
// Only instantiated when HOST_AXIL_TIMEOUT_EN is defined.
module host_axil_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is flagged in the limit cycle itself so the bridge can leave on that edge.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/host_axil_bridge.sv
// Host register request port to a single AXI4-Lite manager port, one transaction at a time.
// Define HOST_AXIL_TIMEOUT_EN to add the response watchdog and the DRAIN state.
module host_axil_bridge
    import host_axil_pkg::*;
#(
    parameter int HOST_ADDR_BITS     = 8,
    parameter int HOST_DATA_BITS     = 32,
    parameter int HOST_AXI_ADDR_BITS = 6,
    parameter int HOST_AXI_DATA_BITS = 32,
    parameter int HOST_AXI_STRB_BITS = HOST_AXI_DATA_BITS / 8,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          host_req_valid,
    input  logic                          host_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0]     host_req_addr,
    input  logic [HOST_DATA_BITS-1:0]     host_req_value,
    input  logic [HOST_AXI_STRB_BITS-1:0] host_req_strb,
    output logic                          host_req_deq,
    output logic                          host_resp_valid,
    input  logic                          host_resp_ready,
    output logic                          host_resp_opcode,
    output logic                          host_resp_err,
    output logic [HOST_DATA_BITS-1:0]     host_resp_bits,
    host_axil_bridge_if.master            s_axi_control
);

    if ((HOST_AXI_ADDR_BITS > HOST_ADDR_BITS) || (HOST_AXI_DATA_BITS != HOST_DATA_BITS) ||
        (TIMEOUT_CYCLES < 2)) begin : g_bad_params
        $error("host_axil_bridge: inconsistent parameters");
    end

    state_t                          state;
    logic                            opcode_q;
    logic [HOST_AXI_ADDR_BITS-1:0]   addr_q;
    logic [HOST_DATA_BITS-1:0]       value_q;
    logic [HOST_AXI_STRB_BITS-1:0]   strb_q;
    logic                            awvalid_q;
    logic                            wvalid_q;
    logic                            arvalid_q;
    logic                            rready_q;
    logic                            bready_q;
    logic                            aw_done;
    logic                            w_done;
    logic                            aw_fire;
    logic                            w_fire;
    logic                            out_of_range;
    logic                            expired;
`ifdef HOST_AXIL_TIMEOUT_EN
    logic                            drain_q;
    logic                            wait_resp;

    assign wait_resp = (state == RD_DATA) || (state == WR_RESP);

    host_axil_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!wait_resp),
        .enable  (wait_resp),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Gated by reset_n so the dequeue strobe drops the instant reset is asserted.
    assign host_req_deq = reset_n && (state == IDLE) && host_req_valid;
    assign out_of_range = |(host_req_addr >> HOST_AXI_ADDR_BITS);
    assign aw_fire      = awvalid_q && s_axi_control.awready;
    assign w_fire       = wvalid_q && s_axi_control.wready;

    assign s_axi_control.awvalid = awvalid_q;
    assign s_axi_control.awaddr  = addr_q;
    assign s_axi_control.wvalid  = wvalid_q;
    assign s_axi_control.wdata   = value_q;
    assign s_axi_control.wstrb   = strb_q;
    assign s_axi_control.arvalid = arvalid_q;
    assign s_axi_control.araddr  = addr_q;
    assign s_axi_control.rready  = rready_q;
    assign s_axi_control.bready  = bready_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            opcode_q         <= 1'b0;
            addr_q           <= '0;
            value_q          <= '0;
            strb_q           <= '0;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            rready_q         <= 1'b0;
            bready_q         <= 1'b0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            host_resp_valid  <= 1'b0;
            host_resp_opcode <= 1'b0;
            host_resp_err    <= 1'b0;
            host_resp_bits   <= '0;
`ifdef HOST_AXIL_TIMEOUT_EN
            drain_q          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (host_req_valid) begin
                        opcode_q         <= host_req_opcode;
                        addr_q           <= host_req_addr[HOST_AXI_ADDR_BITS-1:0];
                        value_q          <= host_req_value;
                        strb_q           <= host_req_strb;
                        host_resp_opcode <= host_req_opcode;
                        if (out_of_range) begin
                            host_resp_valid <= 1'b1;
                            host_resp_err   <= 1'b1;
                            host_resp_bits  <= '0;
                            state           <= RESP;
                        end else if (host_req_opcode) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (s_axi_control.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s_axi_control.rvalid) begin
                        rready_q        <= 1'b0;
                        host_resp_bits  <= s_axi_control.rdata;
                        host_resp_err   <= resp_is_err(s_axi_control.rresp);
                        host_resp_valid <= 1'b1;
                        state           <= RESP;
                    end else if (expired) begin
                        rready_q        <= 1'b0;
                        host_resp_bits  <= HOST_DATA_BITS'(TIMEOUT_DATA);
                        host_resp_err   <= 1'b1;
                        host_resp_valid <= 1'b1;
                        state           <= RESP;
`ifdef HOST_AXIL_TIMEOUT_EN
                        drain_q         <= 1'b1;
`endif
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; leave only when both have.
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axi_control.bvalid) begin
                        bready_q        <= 1'b0;
                        host_resp_bits  <= '0;
                        host_resp_err   <= resp_is_err(s_axi_control.bresp);
                        host_resp_valid <= 1'b1;
                        state           <= RESP;
                    end else if (expired) begin
                        bready_q        <= 1'b0;
                        host_resp_bits  <= HOST_DATA_BITS'(TIMEOUT_DATA);
                        host_resp_err   <= 1'b1;
                        host_resp_valid <= 1'b1;
                        state           <= RESP;
`ifdef HOST_AXIL_TIMEOUT_EN
                        drain_q         <= 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (host_resp_ready) begin
                        host_resp_valid <= 1'b0;
                        state           <= IDLE;
`ifdef HOST_AXIL_TIMEOUT_EN
                        // A timed-out transaction still owes a beat; swallow it before idling.
                        if (drain_q) begin
                            drain_q  <= 1'b0;
                            rready_q <= !opcode_q;
                            bready_q <= opcode_q;
                            state    <= DRAIN;
                        end
`endif
                    end
                end
`ifdef HOST_AXIL_TIMEOUT_EN
                DRAIN: begin
                    if ((opcode_q && s_axi_control.bvalid) || (!opcode_q && s_axi_control.rvalid)) begin
                        rready_q <= 1'b0;
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_axil_bridge.sv
// Directed scoreboard bench for host_axil_bridge; timeout scenario runs when HOST_AXIL_TIMEOUT_EN is defined.
module tb_host_axil_bridge;

    localparam int AB  = 8;
    localparam int DB  = 32;
    localparam int XAB = 6;
    localparam int SB  = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          host_req_valid;
    logic          host_req_opcode;
    logic [AB-1:0] host_req_addr;
    logic [DB-1:0] host_req_value;
    logic [SB-1:0] host_req_strb;
    logic          host_req_deq;
    logic          host_resp_valid;
    logic          host_resp_ready;
    logic          host_resp_opcode;
    logic          host_resp_err;
    logic [DB-1:0] host_resp_bits;

    always #5 clock = ~clock;

    host_axil_bridge_if #(.ADDR_BITS(XAB), .DATA_BITS(DB), .STRB_BITS(SB)) axi ();

    host_axil_bridge #(
        .HOST_ADDR_BITS     (AB),
        .HOST_DATA_BITS     (DB),
        .HOST_AXI_ADDR_BITS (XAB),
        .HOST_AXI_DATA_BITS (DB),
        .HOST_AXI_STRB_BITS (SB),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .host_req_valid   (host_req_valid),
        .host_req_opcode  (host_req_opcode),
        .host_req_addr    (host_req_addr),
        .host_req_value   (host_req_value),
        .host_req_strb    (host_req_strb),
        .host_req_deq     (host_req_deq),
        .host_resp_valid  (host_resp_valid),
        .host_resp_ready  (host_resp_ready),
        .host_resp_opcode (host_resp_opcode),
        .host_resp_err    (host_resp_err),
        .host_resp_bits   (host_resp_bits),
        .s_axi_control    (axi)
    );

    typedef struct packed {
        logic          op;
        logic          err;
        logic [DB-1:0] bits;
    } resp_t;

    resp_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic resp_t mkResp(input logic op, input logic err, input logic [DB-1:0] bits);
        resp_t r;
        r.op   = op;
        r.err  = err;
        r.bits = bits;
        return r;
    endfunction

    // Presents one request in a fresh cycle and checks it is dequeued that same cycle.
    task automatic applyStimulus(input logic op, input logic [AB-1:0] addr,
                                 input logic [DB-1:0] value, input logic [SB-1:0] strb);
        tick();
        host_req_valid  = 1'b1;
        host_req_opcode = op;
        host_req_addr   = addr;
        host_req_value  = value;
        host_req_strb   = strb;
        @(negedge clock);
        checkOutput("req_deq", 32'(host_req_deq), 32'd1);
    endtask

    task automatic runRead(input logic [AB-1:0] addr, input logic [DB-1:0] data,
                           input logic [1:0] resp, input logic err);
        axi.arready = 1'b1;
        exp_q.push_back(mkResp(1'b0, err, data));
        applyStimulus(1'b0, addr, '0, '0);
        tick();
        host_req_valid = 1'b0;
        @(negedge clock);
        checkOutput("rd_arvalid", 32'(axi.arvalid), 32'd1);
        checkOutput("rd_araddr", 32'(axi.araddr), 32'(addr[XAB-1:0]));
        tick();
        axi.rvalid = 1'b1;
        axi.rdata  = data;
        axi.rresp  = resp;
        @(negedge clock);
        checkOutput("rd_rready", 32'(axi.rready), 32'd1);
        checkOutput("rd_arvalid_drop", 32'(axi.arvalid), 32'd0);
        tick();
        axi.rvalid = 1'b0;
        @(negedge clock);
        checkOutput("rd_resp_cycle3", 32'(host_resp_valid), 32'd1);
        tick();
        @(negedge clock);
        checkOutput("rd_resp_gone", 32'(host_resp_valid), 32'd0);
    endtask

    // Scoreboard monitor: every accepted response is compared with the oldest expectation.
    always @(negedge clock) begin
        resp_t e;
        if (reset_n === 1'b1 && host_resp_valid === 1'b1 && host_resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_unexpected actual=op%0d err%0d bits=%h required=no response",
                         host_resp_opcode, host_resp_err, host_resp_bits);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_opcode", 32'(host_resp_opcode), 32'(e.op));
                checkOutput("sb_err", 32'(host_resp_err), 32'(e.err));
                checkOutput("sb_bits", host_resp_bits, e.bits);
            end
        end
    end

    initial begin
        reset_n         = 1'b0;
        host_req_valid  = 1'b1;
        host_req_opcode = 1'b0;
        host_req_addr   = '0;
        host_req_value  = '0;
        host_req_strb   = '0;
        host_resp_ready = 1'b1;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;

        // Reset state, with a request pending to prove dequeue is held off.
        @(negedge clock);
        checkOutput("rst_deq", 32'(host_req_deq), 32'd0);
        checkOutput("rst_arvalid", 32'(axi.arvalid), 32'd0);
        checkOutput("rst_awvalid", 32'(axi.awvalid), 32'd0);
        checkOutput("rst_wvalid", 32'(axi.wvalid), 32'd0);
        checkOutput("rst_resp_valid", 32'(host_resp_valid), 32'd0);
        checkOutput("rst_resp_bits", host_resp_bits, 32'd0);
        tick();
        host_req_valid = 1'b0;
        reset_n        = 1'b1;

        $display("[TB] best-case read");
        runRead(8'h10, 32'hCAFE_0001, 2'b00, 1'b0);

        $display("[TB] write with split AW/W handshakes and SLVERR");
        exp_q.push_back(mkResp(1'b1, 1'b1, 32'h0));
        applyStimulus(1'b1, 8'h04, 32'h1234_5678, 4'h3);
        tick();
        host_req_valid = 1'b0;
        axi.awready    = 1'b1;
        @(negedge clock);
        checkOutput("wr_awvalid_c1", 32'(axi.awvalid), 32'd1);
        checkOutput("wr_wvalid_c1", 32'(axi.wvalid), 32'd1);
        checkOutput("wr_awaddr", 32'(axi.awaddr), 32'h04);
        checkOutput("wr_wstrb", 32'(axi.wstrb), 32'h3);
        checkOutput("wr_wdata", axi.wdata, 32'h1234_5678);
        for (int c = 2; c <= 4; c++) begin
            tick();
            axi.awready = 1'b0;
            axi.wready  = (c == 4);
            @(negedge clock);
            checkOutput("wr_awvalid_dropped", 32'(axi.awvalid), 32'd0);
            checkOutput("wr_wvalid_held", 32'(axi.wvalid), 32'd1);
        end
        tick();
        axi.wready = 1'b0;
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b10;
        @(negedge clock);
        checkOutput("wr_wvalid_dropped", 32'(axi.wvalid), 32'd0);
        checkOutput("wr_bready", 32'(axi.bready), 32'd1);
        tick();
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        @(negedge clock);
        checkOutput("wr_resp_valid", 32'(host_resp_valid), 32'd1);

        $display("[TB] out-of-range read");
        exp_q.push_back(mkResp(1'b0, 1'b1, 32'h0));
        applyStimulus(1'b0, 8'hC0, '0, '0);
        tick();
        host_req_valid = 1'b0;
        @(negedge clock);
        checkOutput("oor_resp_valid", 32'(host_resp_valid), 32'd1);
        checkOutput("oor_no_arvalid", 32'(axi.arvalid), 32'd0);
        tick();
        @(negedge clock);
        checkOutput("oor_no_arvalid_later", 32'(axi.arvalid), 32'd0);

        $display("[TB] response backpressure");
        host_resp_ready = 1'b0;
        axi.arready     = 1'b1;
        exp_q.push_back(mkResp(1'b0, 1'b0, 32'h0000_00AA));
        applyStimulus(1'b0, 8'h20, '0, '0);
        tick();
        @(negedge clock);
        checkOutput("bp_no_deq_c1", 32'(host_req_deq), 32'd0);
        tick();
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h0000_00AA;
        tick();
        axi.rvalid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            @(negedge clock);
            checkOutput("bp_resp_valid_held", 32'(host_resp_valid), 32'd1);
            checkOutput("bp_resp_bits_held", host_resp_bits, 32'h0000_00AA);
            checkOutput("bp_no_deq", 32'(host_req_deq), 32'd0);
        end
        tick();
        host_resp_ready = 1'b1;
        @(negedge clock);
        checkOutput("bp_resp_at_ready", 32'(host_resp_valid), 32'd1);
        checkOutput("bp_no_deq_at_ready", 32'(host_req_deq), 32'd0);
        tick();
        exp_q.push_back(mkResp(1'b0, 1'b0, 32'h0000_00BB));
        @(negedge clock);
        checkOutput("bp_deq_after_ready", 32'(host_req_deq), 32'd1);
        tick();
        host_req_valid = 1'b0;
        @(negedge clock);
        checkOutput("bp_second_arvalid", 32'(axi.arvalid), 32'd1);
        tick();
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h0000_00BB;
        tick();
        axi.rvalid = 1'b0;
        @(negedge clock);
        checkOutput("bp_second_resp", 32'(host_resp_valid), 32'd1);

        $display("[TB] read with DECERR");
        runRead(8'h3C, 32'h0BAD_0BAD, 2'b11, 1'b1);

        $display("[TB] reset during write request");
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        applyStimulus(1'b1, 8'h08, 32'hFFFF_0000, 4'hF);
        tick();
        host_req_valid = 1'b0;
        @(negedge clock);
        checkOutput("rstw_awvalid_before", 32'(axi.awvalid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rstw_awvalid_async", 32'(axi.awvalid), 32'd0);
        checkOutput("rstw_wvalid_async", 32'(axi.wvalid), 32'd0);
        checkOutput("rstw_wdata_async", axi.wdata, 32'd0);
        tick();
        reset_n = 1'b1;
        runRead(8'h0C, 32'h5555_0000, 2'b00, 1'b0);

`ifdef HOST_AXIL_TIMEOUT_EN
        $display("[TB] read timeout and drain");
        axi.arready = 1'b1;
        exp_q.push_back(mkResp(1'b0, 1'b1, 32'hDEAD_BEEF));
        applyStimulus(1'b0, 8'h14, '0, '0);
        tick();
        host_req_valid = 1'b0;
        for (int c = 2; c <= 17; c++) begin
            tick();
            @(negedge clock);
            checkOutput("to_waiting_rready", 32'(axi.rready), 32'd1);
            checkOutput("to_waiting_no_resp", 32'(host_resp_valid), 32'd0);
        end
        tick();
        @(negedge clock);
        checkOutput("to_resp_valid", 32'(host_resp_valid), 32'd1);
        tick();
        @(negedge clock);
        checkOutput("to_drain_rready", 32'(axi.rready), 32'd1);
        checkOutput("to_drain_no_resp", 32'(host_resp_valid), 32'd0);
        tick();
        tick();
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h7777_7777;
        @(negedge clock);
        checkOutput("to_drain_rready_late", 32'(axi.rready), 32'd1);
        tick();
        axi.rvalid = 1'b0;
        @(negedge clock);
        checkOutput("to_drained_rready", 32'(axi.rready), 32'd0);
        checkOutput("to_drained_no_resp", 32'(host_resp_valid), 32'd0);
        runRead(8'h18, 32'h0000_1111, 2'b00, 1'b0);
`endif

        tick();
        tick();
        @(negedge clock);
        checkOutput("sb_all_consumed", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
